// File: rtl/calc_alu_seq.sv
// Multi-cycle add/sub/multiply sequencer built around one shared WIDTH-bit adder.
// Multiply is sign-magnitude shift-add (WIDTH passes) followed by a sign-fix pass.
module calc_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDSUB,
        S_MUL,
        S_SIGN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sub_q, sub_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   add_x, add_y;
    logic               add_cin;
    logic [WIDTH:0]     add_sum;
    logic               op_onehot;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign add_sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign op_onehot = (op == 3'b001) || (op == 3'b010) || (op == 3'b100);
    assign mag_a     = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
    assign mag_b     = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state_q)
            S_ADDSUB: begin
                add_x   = a_q;
                add_y   = sub_q ? ~b_q : b_q;
                add_cin = sub_q;
            end
            S_MUL: begin
                add_x = prod_q[2*WIDTH-1:WIDTH];
                add_y = mcand_q;
            end
            S_SIGN: begin
                add_x   = ~prod_q[WIDTH-1:0];
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sub_d    = sub_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start && op_onehot) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = op[1];
                    neg_d   = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    mcand_d = mag_a;
                    prod_d  = {{WIDTH{1'b0}}, mag_b};
                    cnt_d   = '0;
                    state_d = op[2] ? S_MUL : S_ADDSUB;
                end
            end
            S_ADDSUB: begin
                result_d = add_sum[WIDTH-1:0];
                if (sub_q)
                    ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
                else
                    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
                state_d = S_DONE;
            end
            S_MUL: begin
                // Multiplier sits in the low half; the adder carry becomes the new top bit.
                if (prod_q[0])
                    prod_d = {add_sum, prod_q[WIDTH-1:1]};
                else
                    prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST)
                    state_d = S_SIGN;
            end
            S_SIGN: begin
                result_d = neg_q ? add_sum[WIDTH-1:0] : prod_q[WIDTH-1:0];
                // Magnitude fits iff < 2^(W-1), or == 2^(W-1) when the result is negative.
                ovf_d = (|prod_q[2*WIDTH-1:WIDTH]) ||
                        (prod_q[WIDTH-1] && (!neg_q || (|prod_q[WIDTH-2:0])));
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= S_IDLE;
            sub_q    <= 1'b0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sub_q    <= sub_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign overflow = ovf_q;

endmodule
